dense_seq_mac: RTL and testbench
================================

DENSE_SEQ_MAC -- requirements
Module: dense_seq_mac

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 4: input activations per beat.
REQ-002 SHALL have parameter NUM_CYC, default 8: beats per sample, minimum 1.
REQ-003 SHALL have parameter OUTPUT_SIZE, default 16: output neurons.
REQ-004 SHALL have parameter BW, default 16: signed activation width, input and output.
REQ-005 SHALL have parameter BW_W, default 8: signed weight width.
REQ-006 SHALL have parameter ACC_BW, default 40: signed accumulator width.
REQ-007 SHALL have parameter R_SHIFT, default 8: arithmetic right shift applied before saturation.
REQ-008 SHALL have parameter RELU, default 0: when 1, negative results are clamped to 0.
REQ-009 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-010 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-011 SHALL have port vld_in, input, 1 bit: beat valid.
REQ-012 SHALL have port sof_in, input, 1 bit: first beat of a sample; qualified by vld_in.
REQ-013 SHALL have port data_in, input, INPUT_SIZE*BW bits: activation i at bits [i*BW +: BW].
REQ-014 SHALL have port w_idx, output, max(1,clog2(NUM_CYC)) bits: index of the beat expected next; selects the external weight row.
REQ-015 SHALL have port w_vec, input, OUTPUT_SIZE*INPUT_SIZE*BW_W bits: weight (o,i) at bits [(o*INPUT_SIZE+i)*BW_W +: BW_W]; valid combinationally in the same cycle as vld_in.
REQ-016 SHALL have port vld_out, output, 1 bit: one-cycle pulse when data_out holds a new result.
REQ-017 SHALL have port data_out, output, OUTPUT_SIZE*BW bits: neuron o at bits [o*BW +: BW].
REQ-018 SHALL have port sync_err, output, 1 bit: sticky flag for a sample aborted by an early sof_in.

Function
REQ-019 SHALL keep beat counter cnt equal to w_idx; cnt increments on each vld_in and wraps from NUM_CYC-1 to 0.
REQ-020 SHALL treat a beat as "first" when cnt==0 or sof_in=1, and as "last" when cnt==NUM_CYC-1; with NUM_CYC=1, every beat is both first and last.
REQ-021 SHALL, when vld_in & sof_in & cnt!=0, set sync_err, discard the partial sample, take this beat as beat 0, and set cnt to 1 (or to 0 if NUM_CYC=1).
REQ-022 SHALL run stage 1: in the cycle after an accepted beat, register partial[o] = sum over i of data_in[i]*w_vec[o][i], full-precision signed and sign-extended to ACC_BW, together with its first/last flags.
REQ-023 SHALL run stage 2: on a stage-1 valid beat, acc[o] is loaded with partial[o] if first, otherwise acc[o]+partial[o]; ACC_BW wrap-around is accepted.
REQ-024 SHALL, on a stage-2 last beat, take the final sum s = (first ? partial : acc+partial), shift it arithmetically right by R_SHIFT (floor), saturate to [-2^(BW-1), 2^(BW-1)-1], apply ReLU if RELU=1, register the result to data_out, pulse vld_out, and clear acc.
REQ-025 SHALL assert vld_out exactly 2 cycles after the cycle in which the last beat's vld_in was sampled.
REQ-026 SHALL hold data_out between pulses.
REQ-027 SHALL accept back-to-back samples with no gap, so full throughput is one sample per NUM_CYC cycles.
REQ-028 SHALL let idle cycles (vld_in=0) between beats leave cnt, acc and the pipeline contents unchanged.
REQ-029 SHALL ignore sof_in when vld_in=0.
REQ-030 SHALL provide no backpressure; the downstream block always accepts.

Reset
REQ-031 SHALL, on rst, clear cnt, acc, the stage-1 registers, vld_out, data_out and sync_err to 0.
REQ-032 SHALL, on rst asserted mid-sample, discard the partial sample with no vld_out, and treat the first vld_in after rst as beat 0.
REQ-033 SHALL give rst priority over vld_in in the same cycle; that beat is dropped.

Verification
Bench parameters: INPUT_SIZE=2, NUM_CYC=2, OUTPUT_SIZE=2, BW=16, BW_W=8, R_SHIFT=0 unless stated.
REQ-034 Ones: 2 beats with data_in=1 and all weights=1 -> vld_out 2 cycles after beat 1, each output=4; w_idx goes 0,1,0.
REQ-035 Saturation: data_in=0x7FFF, weights=127 -> outputs 0x7FFF; weights=-128 -> 0x8000 with RELU=0, 0x0000 with RELU=1.
REQ-036 Resync: beat0 (data_in=5), then a beat with sof_in=1 and data_in=1, then beat1 with data_in=1, weights=1 -> sync_err=1, single vld_out, outputs=4.
REQ-037 Back-to-back: 3 samples on consecutive cycles with no gaps -> 3 vld_out pulses spaced 2 cycles apart, correct values each.
REQ-038 Gaps and reset: 3 idle cycles between beats give an unchanged result; rst after beat0 gives no vld_out, the next sample is correct and sync_err=0.
REQ-039 Shift: R_SHIFT=2, sum=-5 -> output -2 (floor).

Source files
------------

// File: rtl/dense_seq_mac.sv
// dense_seq_mac: sequential dense layer. A sample arrives as NUM_CYC beats
// of INPUT_SIZE activations, and each neuron accumulates over the beats.
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   vld_in, sof_in   beat valid; first-beat marker (qualified by vld_in)
//   data_in          INPUT_SIZE signed activations, BW bits each
//   w_idx            beat index expected next (selects the weight row)
//   w_vec            OUTPUT_SIZE x INPUT_SIZE signed weights for that row
//   vld_out          one-cycle pulse when data_out holds a new result
//   data_out         OUTPUT_SIZE signed results, BW bits each
//   sync_err         sticky: a sample was cut short by an early sof_in
module dense_seq_mac #(
  parameter int INPUT_SIZE  = 4,
  parameter int NUM_CYC     = 8,
  parameter int OUTPUT_SIZE = 16,
  parameter int BW          = 16,
  parameter int BW_W        = 8,
  parameter int ACC_BW      = 40,
  parameter int R_SHIFT     = 8,
  parameter int RELU        = 0,
  localparam int CW = (NUM_CYC > 1) ? $clog2(NUM_CYC) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                vld_in,
  input  logic                                sof_in,
  input  logic [INPUT_SIZE*BW-1:0]            data_in,
  output logic [CW-1:0]                       w_idx,
  input  logic [OUTPUT_SIZE*INPUT_SIZE*BW_W-1:0] w_vec,
  output logic                                vld_out,
  output logic [OUTPUT_SIZE*BW-1:0]           data_out,
  output logic                                sync_err
);

  localparam int PW = BW + BW_W;
  localparam logic [CW-1:0] LAST = CW'(NUM_CYC - 1);
  localparam logic signed [ACC_BW-1:0] SAT_MAX =
    {{(ACC_BW-BW+1){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] SAT_MIN =
    {{(ACC_BW-BW+1){1'b1}}, {(BW-1){1'b0}}};

  logic [CW-1:0] cnt_q, cnt_d, eff_cnt;
  logic          err_q, err_d;

  logic          s1_vld_q, s1_vld_d;
  logic          s1_first_q, s1_first_d;
  logic          s1_last_q, s1_last_d;
  logic [OUTPUT_SIZE-1:0][ACC_BW-1:0] p_q, p_d;

  logic [OUTPUT_SIZE-1:0][ACC_BW-1:0] acc_q, acc_d;
  logic                    vo_q, vo_d;
  logic [OUTPUT_SIZE*BW-1:0] out_q, out_d;

  logic signed [PW-1:0]     prod;
  logic signed [ACC_BW-1:0] psum;
  logic signed [ACC_BW-1:0] sum;
  logic signed [ACC_BW-1:0] shv;
  logic signed [ACC_BW-1:0] clp;

  // An early sof_in restarts the sample, so the beat is treated as index 0.
  always_comb begin
    eff_cnt    = sof_in ? '0 : cnt_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    s1_vld_d   = vld_in;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    if (vld_in) begin
      s1_first_d = (cnt_q == '0) | sof_in;
      s1_last_d  = (eff_cnt == LAST);
      cnt_d      = (eff_cnt == LAST) ? '0 : eff_cnt + CW'(1);
      if (sof_in && cnt_q != '0)
        err_d = 1'b1;
    end
  end

  always_comb begin
    p_d  = p_q;
    prod = '0;
    psum = '0;
    if (vld_in) begin
      for (int o = 0; o < OUTPUT_SIZE; o++) begin
        psum = '0;
        for (int i = 0; i < INPUT_SIZE; i++) begin
          prod = PW'($signed(data_in[i*BW +: BW]))
               * PW'($signed(w_vec[(o*INPUT_SIZE+i)*BW_W +: BW_W]));
          psum = psum + ACC_BW'(prod);
        end
        p_d[o] = psum;
      end
    end
  end

  always_comb begin
    acc_d = acc_q;
    out_d = out_q;
    vo_d  = 1'b0;
    sum   = '0;
    shv   = '0;
    clp   = '0;
    if (s1_vld_q) begin
      for (int o = 0; o < OUTPUT_SIZE; o++) begin
        sum = s1_first_q ? $signed(p_q[o])
                         : $signed(acc_q[o]) + $signed(p_q[o]);
        if (s1_last_q) begin
          shv = sum >>> R_SHIFT;
          if (shv > SAT_MAX)
            clp = SAT_MAX;
          else if (shv < SAT_MIN)
            clp = SAT_MIN;
          else
            clp = shv;
          if (RELU != 0 && clp < 0)
            clp = '0;
          out_d[o*BW +: BW] = clp[BW-1:0];
          acc_d[o] = '0;
        end else begin
          acc_d[o] = sum;
        end
      end
      vo_d = s1_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      err_q      <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      p_q        <= '0;
      acc_q      <= '0;
      vo_q       <= 1'b0;
      out_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      s1_vld_q   <= s1_vld_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      p_q        <= p_d;
      acc_q      <= acc_d;
      vo_q       <= vo_d;
      out_q      <= out_d;
    end
  end

  assign w_idx    = cnt_q;
  assign sync_err = err_q;
  assign vld_out  = vo_q;
  assign data_out = out_q;

endmodule

// File: tb/tb_dense_seq_mac.sv
// tb_dense_seq_mac: scoreboard bench for dense_seq_mac.
// Three instances share stimulus: plain, ReLU, and R_SHIFT=2.
module tb_dense_seq_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld_in;
  logic        sof_in;
  logic [31:0] data_in;
  logic [31:0] w_vec;

  logic        w_idx0, w_idx1, w_idx2;
  logic        vo0, vo1, vo2;
  logic [31:0] do0, do1, do2;
  logic        se0, se1, se2;

  always #5 clk = ~clk;

  dense_seq_mac #(
    .INPUT_SIZE(2), .NUM_CYC(2), .OUTPUT_SIZE(2), .BW(16), .BW_W(8),
    .ACC_BW(40), .R_SHIFT(0), .RELU(0)
  ) u_plain (
    .clk(clk), .rst(rst), .vld_in(vld_in), .sof_in(sof_in),
    .data_in(data_in), .w_idx(w_idx0), .w_vec(w_vec),
    .vld_out(vo0), .data_out(do0), .sync_err(se0)
  );

  dense_seq_mac #(
    .INPUT_SIZE(2), .NUM_CYC(2), .OUTPUT_SIZE(2), .BW(16), .BW_W(8),
    .ACC_BW(40), .R_SHIFT(0), .RELU(1)
  ) u_relu (
    .clk(clk), .rst(rst), .vld_in(vld_in), .sof_in(sof_in),
    .data_in(data_in), .w_idx(w_idx1), .w_vec(w_vec),
    .vld_out(vo1), .data_out(do1), .sync_err(se1)
  );

  dense_seq_mac #(
    .INPUT_SIZE(2), .NUM_CYC(2), .OUTPUT_SIZE(2), .BW(16), .BW_W(8),
    .ACC_BW(40), .R_SHIFT(2), .RELU(0)
  ) u_shift (
    .clk(clk), .rst(rst), .vld_in(vld_in), .sof_in(sof_in),
    .data_in(data_in), .w_idx(w_idx2), .w_vec(w_vec),
    .vld_out(vo2), .data_out(do2), .sync_err(se2)
  );

  typedef struct {
    logic [31:0] d;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int     m_cnt;
  int     m_err;
  longint m_acc[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] post(input longint s, input int sh,
                                       input bit relu);
    longint v;
    v = s >>> sh;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    if (relu && v < 0) v = 0;
    return v[15:0];
  endfunction

  function automatic logic [31:0] dv(input int a0, input int a1);
    return {a1[15:0], a0[15:0]};
  endfunction

  function automatic logic [31:0] wv(input int w00, input int w01,
                                     input int w10, input int w11);
    return {w11[7:0], w10[7:0], w01[7:0], w00[7:0]};
  endfunction

  function automatic int pend();
    return q0.size() + q1.size() + q2.size();
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (vo0) begin
      if (q0.size() == 0) chk("spurious_plain", 1, 0);
      else begin
        e = q0.pop_front();
        chk("data_plain", do0, e.d);
        chk("lat_plain", cyc, e.cyc);
      end
    end
    if (vo1) begin
      if (q1.size() == 0) chk("spurious_relu", 1, 0);
      else begin
        e = q1.pop_front();
        chk("data_relu", do1, e.d);
        chk("lat_relu", cyc, e.cyc);
      end
    end
    if (vo2) begin
      if (q2.size() == 0) chk("spurious_shift", 1, 0);
      else begin
        e = q2.pop_front();
        chk("data_shift", do2, e.d);
        chk("lat_shift", cyc, e.cyc);
      end
    end
  end

  task automatic beat(input logic [31:0] d, input logic [31:0] w,
                      input logic sof);
    longint s[2];
    longint p;
    bit     first, last;
    int     eff;
    exp_t   e0, e1, e2;
    @(posedge clk); #1;
    chk("w_idx", w_idx0, m_cnt);
    chk("sync_err", se0, m_err);
    vld_in  = 1'b1;
    sof_in  = sof;
    data_in = d;
    w_vec   = w;
    first = (m_cnt == 0) || sof;
    if (sof && m_cnt != 0) m_err = 1;
    eff  = sof ? 0 : m_cnt;
    last = (eff == 1);
    for (int o = 0; o < 2; o++) begin
      p = 0;
      for (int i = 0; i < 2; i++)
        p += longint'($signed(d[i*16 +: 16]))
           * longint'($signed(w[(o*2+i)*8 +: 8]));
      s[o] = first ? p : m_acc[o] + p;
      m_acc[o] = last ? 0 : s[o];
    end
    m_cnt = last ? 0 : eff + 1;
    if (last) begin
      for (int o = 0; o < 2; o++) begin
        e0.d[o*16 +: 16] = post(s[o], 0, 0);
        e1.d[o*16 +: 16] = post(s[o], 0, 1);
        e2.d[o*16 +: 16] = post(s[o], 2, 0);
      end
      e0.cyc = cyc + 2;
      e1.cyc = cyc + 2;
      e2.cyc = cyc + 2;
      q0.push_back(e0);
      q1.push_back(e1);
      q2.push_back(e2);
    end
  endtask

  // sof_in is held high while idle: it must be ignored without vld_in.
  task automatic idle(input int n);
    @(posedge clk); #1;
    vld_in = 1'b0;
    sof_in = 1'b1;
    data_in = 32'hDEAD_BEEF;
    repeat (n - 1) @(posedge clk);
    #1 sof_in = 1'b0;
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 20 && pend() != 0; i++) @(posedge clk);
    chk("drain", pend(), 0);
  endtask

  // A beat presented during rst must be dropped.
  task automatic do_reset(input logic with_beat);
    @(posedge clk); #1;
    rst     = 1'b1;
    vld_in  = with_beat;
    sof_in  = 1'b0;
    data_in = dv(100, 100);
    @(posedge clk); #1;
    rst    = 1'b0;
    vld_in = 1'b0;
    m_cnt  = 0;
    m_err  = 0;
    m_acc[0] = 0;
    m_acc[1] = 0;
  endtask

  initial begin
    rst     = 1'b1;
    vld_in  = 1'b0;
    sof_in  = 1'b0;
    data_in = '0;
    w_vec   = '0;
    m_cnt   = 0;
    m_err   = 0;
    m_acc[0] = 0;
    m_acc[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld_out", vo0, 0);
    chk("rst_data_out", do0, 0);
    chk("rst_sync_err", se0, 0);
    chk("rst_w_idx", w_idx0, 0);
    rst = 1'b0;

    // ones: each output 4
    beat(dv(1, 1), wv(1, 1, 1, 1), 1'b1);
    beat(dv(1, 1), wv(1, 1, 1, 1), 1'b0);
    drain();
    chk("ones_value", do0, 32'h0004_0004);

    // saturation, both polarities
    beat(dv(32767, 32767), wv(127, 127, 127, 127), 1'b0);
    beat(dv(32767, 32767), wv(127, 127, 127, 127), 1'b0);
    beat(dv(32767, 32767), wv(-128, -128, -128, -128), 1'b0);
    beat(dv(32767, 32767), wv(-128, -128, -128, -128), 1'b0);
    drain();
    chk("sat_neg_plain", do0, 32'h8000_8000);
    chk("sat_neg_relu", do1, 32'h0000_0000);

    // resync: early sof_in aborts the partial sample
    beat(dv(5, 5), wv(1, 1, 1, 1), 1'b1);
    beat(dv(1, 1), wv(1, 1, 1, 1), 1'b1);
    beat(dv(1, 1), wv(1, 1, 1, 1), 1'b0);
    drain();
    chk("resync_value", do0, 32'h0004_0004);
    chk("resync_err", se0, 1);

    // back-to-back samples, mixed weights
    beat(dv(3, -2), wv(2, 1, -1, 4), 1'b1);
    beat(dv(7, 1), wv(-3, 5, 2, 2), 1'b0);
    beat(dv(-9, 4), wv(1, 1, 6, -7), 1'b0);
    beat(dv(2, 2), wv(3, 3, -2, 1), 1'b0);
    beat(dv(100, -50), wv(10, 20, -30, 40), 1'b0);
    beat(dv(-1, 8), wv(9, -9, 1, 1), 1'b0);

    // idle gap between beats
    beat(dv(11, 12), wv(1, 2, 3, 4), 1'b0);
    idle(3);
    beat(dv(13, 14), wv(5, 6, 7, 8), 1'b0);
    drain();

    // reset mid-sample, with a beat presented during reset
    beat(dv(50, 50), wv(1, 1, 1, 1), 1'b0);
    do_reset(1'b1);
    chk("mid_rst_err", se0, 0);
    beat(dv(2, 3), wv(1, 1, 1, 1), 1'b0);
    beat(dv(4, 5), wv(1, 1, 1, 1), 1'b0);
    drain();
    chk("post_rst_value", do0, 32'h000E_000E);

    // floor shift: sum -5
    beat(dv(-5, 0), wv(1, 1, 1, 1), 1'b0);
    beat(dv(0, 0), wv(1, 1, 1, 1), 1'b0);
    drain();
    chk("shift_floor", do2, 32'hFFFE_FFFE);
    chk("shift_hold", do2, 32'hFFFE_FFFE);

    // random samples
    for (int k = 0; k < 20; k++) begin
      int a, b;
      a = int'($urandom_range(0, 4000)) - 2000;
      b = int'($urandom_range(0, 4000)) - 2000;
      beat(dv(a, b),
           wv(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255))),
           1'b0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
